lf_pck_divider: RTL and testbench
=================================

Name: lf_pck_divider

Overview:
- Programmable LF carrier divider. Runs on the 24 MHz pck0 and produces the pck_cnt phase counter and the pck_divclk carrier.
- Sits directly upstream of the LF read/serialiser stage. That stage samples the ADC at pck_cnt==7 while pck_divclk is low, and shifts the sample out on counts 8..15.
- The divisor comes from ARM configuration. Divisor changes take effect only on full-period boundaries, so the carrier never glitches.

Parameters:
- DEFAULT_DIV, 95, divisor loaded at reset. 95 gives 24 MHz / (2*96) = 125 kHz.
- MIN_DIV, 15, smallest divisor accepted. Guarantees pck_cnt reaches 15 in every half-period. Legal only if MIN_DIV <= DEFAULT_DIV <= 255.

Ports:
- pck0  input  1  24 MHz clock; all logic on its rising edge.
- nreset  input  1  asynchronous active-low reset.
- en  input  1  divider enable, synchronous.
- divisor  input  8  requested half-period length minus one.
- div_load  input  1  one-cycle strobe that captures divisor.
- pck_cnt  output  8  phase counter, 0..div_act.
- pck_divclk  output  1  carrier. Low half-period first, then high half-period.
- period_start  output  1  one-cycle pulse, high in the first cycle of each full period.
- div_active  output  8  divisor currently in use (div_act).

Behaviour:
- Registers: cnt[7:0], divclk, div_act[7:0], div_pend[7:0], pend_valid, period_start, en_d. All outputs are driven directly from registers.
- Reset (nreset low, asynchronous):
  - cnt=0, divclk=0, period_start=0, pend_valid=0, en_d=0.
  - div_act=DEFAULT_DIV, div_pend=DEFAULT_DIV.
  - A reset mid-period abandons that period. A pending load is discarded.
- Clamp rule: clampdiv = (divisor < MIN_DIV) ? MIN_DIV : divisor.
- Load:
  - If div_load is high: div_pend <= clampdiv, pend_valid <= 1.
  - If several loads arrive before a boundary, only the last one survives.
- Counting (en=1):
  - If cnt != div_act: cnt <= cnt+1.
  - If cnt == div_act: cnt <= 0 and divclk <= ~divclk. This is a half-period wrap.
  - Each half-period lasts div_act+1 cycles. A full period lasts 2*(div_act+1) cycles.
  - pck_divclk only toggles in the cycle where pck_cnt returns to 0.
- Boundary: cnt == div_act && divclk == 1 && en == 1. This is the end of the high half.
  - If pend_valid: div_act <= div_pend and pend_valid <= 0.
  - If div_load is also high in the boundary cycle:
    - the old div_pend is applied;
    - the new clampdiv is captured into div_pend;
    - pend_valid stays 1, and the new value is applied at the following boundary.
  - A wrap at the end of the low half never changes div_act.
- period_start:
  - period_start <= boundary | (en & ~en_d), with en_d <= en.
  - It is therefore high in the cycle where cnt=0 and divclk=0 starts a period.
- Disable (en=0):
  - cnt <= 0 and divclk <= 0, synchronously, next edge.
  - Loads are still accepted.
  - If pend_valid, div_act <= div_pend and pend_valid <= 0. Pending values apply immediately while disabled.
  - period_start stays 0.
- Re-enable: the first enabled cycle shows cnt=0, divclk=0, period_start=1, and counting starts from there.
- Invariant: cnt <= div_act at all times. div_act only changes when cnt == 0 is being loaded or when the divider is disabled, so overflow past div_act cannot occur.
- Arithmetic: 8-bit unsigned. Maximum divisor 255 gives a full period of 512 cycles (46.875 kHz).

Test Plan:
- Reset with en=1, no loads:
  - div_active=95;
  - pck_divclk low for 96 cycles then high for 96, period 192;
  - period_start pulses every 192 cycles;
  - pck_cnt sequence 0..95,0..95.
- Load divisor=63 at cycle 40 of the low half:
  - div_active stays 95 until the end of the following high half;
  - after that, 64-cycle halves (187.5 kHz);
  - no half-period shorter than 64 cycles or longer than 96 cycles.
- Load divisor=3:
  - div_active becomes 15 (clamped);
  - period 32 cycles;
  - pck_cnt reaches 15 in every half.
- Load 50 then 70 before one boundary:
  - only 70 is applied.
- Load 80 in the boundary cycle while 50 is pending:
  - 50 is applied at this boundary;
  - 80 is applied one full period of 102 cycles later.
- en low mid-high-half at pck_cnt=30, load 47, en high after 10 cycles:
  - while disabled: pck_cnt=0, pck_divclk=0, div_active=47;
  - on re-enable: period_start=1 on the first cycle, then 48-cycle halves.
- nreset pulsed asynchronously mid-period with a pending load:
  - outputs go to reset values immediately, without waiting for a clock edge;
  - pending load lost;
  - div_active=95 after release.

Source files
------------

// File: rtl/lf_pck_divider.sv
// rtl/lf_pck_divider.sv - programmable LF carrier divider producing pck_cnt and pck_divclk
module lf_pck_divider #(
  parameter int DEFAULT_DIV = 95,
  parameter int MIN_DIV     = 15
) (
  input  logic       pck0,
  input  logic       nreset,
  input  logic       en,
  input  logic [7:0] divisor,
  input  logic       div_load,
  output logic [7:0] pck_cnt,
  output logic       pck_divclk,
  output logic       period_start,
  output logic [7:0] div_active
);

  localparam logic [7:0] DEF_DIV8 = 8'(DEFAULT_DIV);
  localparam logic [7:0] MIN_DIV8 = 8'(MIN_DIV);

  logic [7:0] r_cnt;
  logic       r_divclk;
  logic [7:0] r_div_act;
  logic [7:0] r_div_pend;
  logic       r_pend_valid;
  logic       r_period_start;
  logic       r_en_d;

  logic [7:0] w_clampdiv;
  logic       w_wrap;
  logic       w_start;
  logic       w_boundary;

  assign w_clampdiv = (divisor < MIN_DIV8) ? MIN_DIV8 : divisor;
  assign w_wrap     = (r_cnt == r_div_act);
  // First enabled cycle after disable/reset is held at count 0 so it is the period's first cycle.
  assign w_start    = en & ~r_en_d;
  assign w_boundary = en & r_en_d & w_wrap & r_divclk;

  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      r_cnt          <= 8'd0;
      r_divclk       <= 1'b0;
      r_div_act      <= DEF_DIV8;
      r_div_pend     <= DEF_DIV8;
      r_pend_valid   <= 1'b0;
      r_period_start <= 1'b0;
      r_en_d         <= 1'b0;
    end else begin
      r_en_d         <= en;
      r_period_start <= w_boundary | w_start;

      if (!en) begin
        r_cnt    <= 8'd0;
        r_divclk <= 1'b0;
        if (r_pend_valid) begin
          r_div_act    <= r_div_pend;
          r_pend_valid <= 1'b0;
        end
      end else if (w_start) begin
        r_cnt    <= 8'd0;
        r_divclk <= 1'b0;
      end else if (w_wrap) begin
        r_cnt    <= 8'd0;
        r_divclk <= ~r_divclk;
        if (r_divclk && r_pend_valid) begin
          r_div_act    <= r_div_pend;
          r_pend_valid <= 1'b0;
        end
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end

      // A load in the same cycle as an apply re-arms the pending slot for the next boundary.
      if (div_load) begin
        r_div_pend   <= w_clampdiv;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign pck_cnt      = r_cnt;
  assign pck_divclk   = r_divclk;
  assign period_start = r_period_start;
  assign div_active   = r_div_act;

endmodule

// File: tb/tb_lf_pck_divider.sv
// tb/tb_lf_pck_divider.sv - directed self-checking bench for lf_pck_divider
module tb_lf_pck_divider;

  logic       pck0 = 1'b0;
  logic       nreset;
  logic       en;
  logic [7:0] divisor;
  logic       div_load;
  logic [7:0] pck_cnt;
  logic       pck_divclk;
  logic       period_start;
  logic [7:0] div_active;

  int errors = 0;
  int checks = 0;

  lf_pck_divider dut (
    .pck0         (pck0),
    .nreset       (nreset),
    .en           (en),
    .divisor      (divisor),
    .div_load     (div_load),
    .pck_cnt      (pck_cnt),
    .pck_divclk   (pck_divclk),
    .period_start (period_start),
    .div_active   (div_active)
  );

  always #5 pck0 = ~pck0;

  task automatic tick;
    @(posedge pck0);
    @(negedge pck0);
  endtask

  task automatic test_reset;
    nreset = 1'b0; en = 1'b1; divisor = 8'd0; div_load = 1'b0;
    @(negedge pck0);
    @(negedge pck0);
    checks++;
    if (pck_cnt !== 8'd0 || pck_divclk !== 1'b0 || period_start !== 1'b0 || div_active !== 8'd95) begin
      errors++;
      $display("FAIL reset_state: cnt=%0d clk=%0b ps=%0b div=%0d, want 0 0 0 95", pck_cnt, pck_divclk, period_start, div_active);
    end
    nreset = 1'b1;
    tick();
    checks++;
    if (period_start !== 1'b1 || pck_cnt !== 8'd0 || pck_divclk !== 1'b0) begin
      errors++;
      $display("FAIL first_start: ps=%0b cnt=%0d clk=%0b, want 1 0 0", period_start, pck_cnt, pck_divclk);
    end
  endtask

  task automatic test_default_period;
    int bad_i = -1;
    for (int i = 0; i < 192; i++) begin
      if (bad_i < 0 && (pck_cnt !== 8'(i % 96) || pck_divclk !== (i >= 96) || period_start !== (i == 0)))
        bad_i = i;
      tick();
    end
    checks++;
    if (bad_i >= 0) begin
      errors++;
      $display("FAIL default_seq: first bad cycle %0d, want no bad cycle", bad_i);
    end
    checks++;
    if (period_start !== 1'b1 || pck_cnt !== 8'd0) begin
      errors++;
      $display("FAIL default_period192: ps=%0b cnt=%0d, want 1 0", period_start, pck_cnt);
    end
  endtask

  task automatic test_load_63;
    int n = 0;
    int bad = 0;
    int bad_i = -1;
    repeat (40) tick();
    checks++;
    if (pck_cnt !== 8'd40 || pck_divclk !== 1'b0) begin
      errors++;
      $display("FAIL load63_pre: cnt=%0d clk=%0b, want 40 0", pck_cnt, pck_divclk);
    end
    divisor = 8'd63; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    do begin
      if (div_active !== 8'd95) bad = 1;
      tick();
      n++;
    end while (period_start !== 1'b1 && n < 600);
    checks++;
    if (n != 151 || bad != 0) begin
      errors++;
      $display("FAIL load63_hold: boundary after %0d cycles early_change=%0d, want 151 0", n, bad);
    end
    for (int i = 0; i < 128; i++) begin
      if (bad_i < 0 && (pck_cnt !== 8'(i % 64) || pck_divclk !== (i >= 64) ||
                        period_start !== (i == 0) || div_active !== 8'd63))
        bad_i = i;
      tick();
    end
    checks++;
    if (bad_i >= 0 || period_start !== 1'b1) begin
      errors++;
      $display("FAIL load63_halves: first bad cycle %0d ps_at_128=%0b, want -1 1", bad_i, period_start);
    end
  endtask

  task automatic test_clamp;
    int n = 0;
    int bad_i = -1;
    divisor = 8'd3; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    do begin tick(); n++; end while (period_start !== 1'b1 && n < 600);
    checks++;
    if (n != 127 || div_active !== 8'd15) begin
      errors++;
      $display("FAIL clamp_apply: cycles=%0d div=%0d, want 127 15", n, div_active);
    end
    for (int i = 0; i < 32; i++) begin
      if (bad_i < 0 && (pck_cnt !== 8'(i % 16) || pck_divclk !== (i >= 16) || period_start !== (i == 0)))
        bad_i = i;
      tick();
    end
    checks++;
    if (bad_i >= 0 || period_start !== 1'b1) begin
      errors++;
      $display("FAIL clamp_period32: first bad cycle %0d ps_at_32=%0b, want -1 1", bad_i, period_start);
    end
  endtask

  task automatic test_last_load_wins;
    int n = 0;
    divisor = 8'd50; div_load = 1'b1;
    tick();
    divisor = 8'd70;
    tick();
    div_load = 1'b0;
    do begin tick(); n++; end while (period_start !== 1'b1 && n < 600);
    checks++;
    if (n != 30 || div_active !== 8'd70) begin
      errors++;
      $display("FAIL last_load: cycles=%0d div=%0d, want 30 70", n, div_active);
    end
    n = 0;
    do begin tick(); n++; end while (period_start !== 1'b1 && n < 600);
    checks++;
    if (n != 142 || div_active !== 8'd70) begin
      errors++;
      $display("FAIL last_load_period: cycles=%0d div=%0d, want 142 70", n, div_active);
    end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    int bad = 0;
    divisor = 8'd50; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    repeat (140) tick();
    checks++;
    if (pck_cnt !== 8'd70 || pck_divclk !== 1'b1) begin
      errors++;
      $display("FAIL b2b_boundary_pos: cnt=%0d clk=%0b, want 70 1", pck_cnt, pck_divclk);
    end
    divisor = 8'd80; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    checks++;
    if (period_start !== 1'b1 || div_active !== 8'd50) begin
      errors++;
      $display("FAIL b2b_first_apply: ps=%0b div=%0d, want 1 50", period_start, div_active);
    end
    do begin
      if (div_active !== 8'd50) bad = 1;
      tick();
      n++;
    end while (period_start !== 1'b1 && n < 600);
    checks++;
    if (n != 102 || bad != 0 || div_active !== 8'd80) begin
      errors++;
      $display("FAIL b2b_second_apply: cycles=%0d early=%0d div=%0d, want 102 0 80", n, bad, div_active);
    end
  endtask

  task automatic test_disable;
    int bad = 0;
    int bad_i = -1;
    repeat (111) tick();
    checks++;
    if (pck_cnt !== 8'd30 || pck_divclk !== 1'b1) begin
      errors++;
      $display("FAIL dis_pre: cnt=%0d clk=%0b, want 30 1", pck_cnt, pck_divclk);
    end
    en = 1'b0;
    tick();
    checks++;
    if (pck_cnt !== 8'd0 || pck_divclk !== 1'b0 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL dis_clear: cnt=%0d clk=%0b ps=%0b, want 0 0 0", pck_cnt, pck_divclk, period_start);
    end
    divisor = 8'd47; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (pck_cnt !== 8'd0 || pck_divclk !== 1'b0 || period_start !== 1'b0) bad = 1;
      tick();
    end
    checks++;
    if (bad != 0 || div_active !== 8'd47) begin
      errors++;
      $display("FAIL dis_hold: moved=%0d div=%0d, want 0 47", bad, div_active);
    end
    en = 1'b1;
    tick();
    checks++;
    if (period_start !== 1'b1 || pck_cnt !== 8'd0 || pck_divclk !== 1'b0) begin
      errors++;
      $display("FAIL reenable_start: ps=%0b cnt=%0d clk=%0b, want 1 0 0", period_start, pck_cnt, pck_divclk);
    end
    for (int i = 0; i < 96; i++) begin
      if (bad_i < 0 && (pck_cnt !== 8'(i % 48) || pck_divclk !== (i >= 48) || period_start !== (i == 0)))
        bad_i = i;
      tick();
    end
    checks++;
    if (bad_i >= 0 || period_start !== 1'b1) begin
      errors++;
      $display("FAIL reenable_halves: first bad cycle %0d ps_at_96=%0b, want -1 1", bad_i, period_start);
    end
  endtask

  task automatic test_async_reset;
    int n = 0;
    divisor = 8'd100; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    repeat (60) tick();
    checks++;
    if (pck_divclk !== 1'b1 || pck_cnt !== 8'd13) begin
      errors++;
      $display("FAIL areset_pre: clk=%0b cnt=%0d, want 1 13", pck_divclk, pck_cnt);
    end
    #2 nreset = 1'b0;
    #1;
    checks++;
    if (pck_cnt !== 8'd0 || pck_divclk !== 1'b0 || period_start !== 1'b0 || div_active !== 8'd95) begin
      errors++;
      $display("FAIL areset_immediate: cnt=%0d clk=%0b ps=%0b div=%0d, want 0 0 0 95", pck_cnt, pck_divclk, period_start, div_active);
    end
    @(negedge pck0);
    nreset = 1'b1;
    tick();
    checks++;
    if (period_start !== 1'b1 || pck_cnt !== 8'd0 || div_active !== 8'd95) begin
      errors++;
      $display("FAIL areset_release: ps=%0b cnt=%0d div=%0d, want 1 0 95", period_start, pck_cnt, div_active);
    end
    do begin tick(); n++; end while (period_start !== 1'b1 && n < 600);
    checks++;
    if (n != 192 || div_active !== 8'd95) begin
      errors++;
      $display("FAIL areset_pend_lost: cycles=%0d div=%0d, want 192 95", n, div_active);
    end
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_load_63();
    test_clamp();
    test_last_load_wins();
    test_back_to_back();
    test_disable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
